// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared CAN field widths, frame type and ID match helper
//
// Purpose: common definitions for the CAN node (can_top, can_rx_filter_fifo).
// No ports.
package can_pkg;

  localparam int CAN_ID_W   = 11;
  localparam int CAN_DLC_W  = 4;
  localparam int CAN_DATA_W = 64;

  // Decoded frame as delivered by can_top; data byte 0 sits in bits [7:0].
  // The receive FIFO entry wraps this with the matching filter index and,
  // when enabled, the capture timestamp (widths depend on block parameters).
  typedef struct packed {
    logic [CAN_ID_W-1:0]   id;
    logic [CAN_DLC_W-1:0]  dlc;
    logic [CAN_DATA_W-1:0] data;
  } can_frame_t;

  // A mask bit of 1 means that ID bit must equal the filter ID bit.
  function automatic logic id_match(input logic [CAN_ID_W-1:0] id,
                                    input logic [CAN_ID_W-1:0] fid,
                                    input logic [CAN_ID_W-1:0] mask);
    return ((id ^ fid) & mask) == '0;
  endfunction

endpackage

// File: rtl/can_sync_fifo.sv
// rtl/can_sync_fifo.sv - show-ahead synchronous FIFO with occupancy count
//
// Purpose: single-clock FIFO; the head entry is visible on pop_data whenever
// empty=0. Pushes while full are ignored unless a pop happens in the same
// cycle, in which case both take effect.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_data write request and data
//   pop             consume head (ignored while empty)
//   pop_data        head entry
//   count           occupancy, 0..DEPTH
//   full, empty     status
module can_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop frees the slot the push needs, so full does not block it then.
  assign do_push = push && (!full || do_pop);

  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/can_rx_filter_fifo.sv
// rtl/can_rx_filter_fifo.sv - CAN receive acceptance filter and frame FIFO
//
// Purpose: matches each received frame against NUM_FILTERS ID/mask banks,
// registers accepted frames in stage S1 and queues them in a DEPTH-entry
// show-ahead FIFO drained with rd_valid/rd_ready.
// Optional feature macro: CAN_RX_TIMESTAMP_EN adds a free-running TS_WIDTH
// counter captured with each frame and presented on rd_ts.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   rx_valid, rx_id, rx_dlc, rx_data  frame pulse from can_top
//   cfg_we, cfg_idx, cfg_id,
//   cfg_mask, cfg_en                  filter bank write
//   rd_valid, rd_ready                read handshake
//   rd_id, rd_dlc, rd_data, rd_filt   head frame (0 while rd_valid=0)
//   rd_ts                             head timestamp (macro only)
//   count, ovf, ovf_clr               occupancy, sticky overflow, clear
module can_rx_filter_fifo
  import can_pkg::*;
#(
  parameter int NUM_FILTERS = 4,
  parameter int DEPTH       = 8,
  parameter int TS_WIDTH    = 16,
  localparam int FILT_W     = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_valid,
  input  logic [CAN_ID_W-1:0]     rx_id,
  input  logic [CAN_DLC_W-1:0]    rx_dlc,
  input  logic [CAN_DATA_W-1:0]   rx_data,
  input  logic                    cfg_we,
  input  logic [FILT_W-1:0]       cfg_idx,
  input  logic [CAN_ID_W-1:0]     cfg_id,
  input  logic [CAN_ID_W-1:0]     cfg_mask,
  input  logic                    cfg_en,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [CAN_ID_W-1:0]     rd_id,
  output logic [CAN_DLC_W-1:0]    rd_dlc,
  output logic [CAN_DATA_W-1:0]   rd_data,
  output logic [FILT_W-1:0]       rd_filt,
`ifdef CAN_RX_TIMESTAMP_EN
  output logic [TS_WIDTH-1:0]     rd_ts,
`endif
  output logic [$clog2(DEPTH):0]  count,
  output logic                    ovf,
  input  logic                    ovf_clr
);

  typedef struct packed {
    can_frame_t          frame;
    logic [FILT_W-1:0]   filt;
`ifdef CAN_RX_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts;
`endif
  } rx_entry_t;

  // Filter banks
  logic [CAN_ID_W-1:0]    f_id   [NUM_FILTERS];
  logic [CAN_ID_W-1:0]    f_mask [NUM_FILTERS];
  logic [NUM_FILTERS-1:0] f_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_FILTERS; k++) begin
        f_id[k]   <= '0;
        f_mask[k] <= '0;
      end
      f_en <= '0;
    end else if (cfg_we && (int'(cfg_idx) < NUM_FILTERS)) begin
      f_id[cfg_idx]   <= cfg_id;
      f_mask[cfg_idx] <= cfg_mask;
      f_en[cfg_idx]   <= cfg_en;
    end
  end

  // Match: scanning downward leaves the lowest matching index in hit_idx.
  logic              hit;
  logic [FILT_W-1:0] hit_idx;
  logic              accept;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = NUM_FILTERS - 1; k >= 0; k--) begin
      if (f_en[k] && id_match(rx_id, f_id[k], f_mask[k])) begin
        hit     = 1'b1;
        hit_idx = FILT_W'(k);
      end
    end
  end

  // With every bank disabled all frames pass; hit_idx is then 0.
  assign accept = (f_en == '0) || hit;

`ifdef CAN_RX_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
    end
  end
`endif

  // Stage S1: rejected frames never become valid here, so the FIFO push is
  // simply s1_valid.
  logic      s1_valid;
  rx_entry_t s1_entry;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_entry <= '0;
    end else begin
      s1_valid <= rx_valid && accept;
      if (rx_valid) begin
        s1_entry.frame.id   <= rx_id;
        s1_entry.frame.dlc  <= rx_dlc;
        s1_entry.frame.data <= rx_data;
        s1_entry.filt       <= hit_idx;
`ifdef CAN_RX_TIMESTAMP_EN
        s1_entry.ts         <= ts_cnt;
`endif
      end
    end
  end

  // FIFO
  rx_entry_t head;
  logic      fifo_full;
  logic      fifo_empty;
  logic      pop;

  assign rd_valid = !fifo_empty;
  assign pop      = rd_valid && rd_ready;

  can_sync_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s1_valid),
    .push_data (s1_entry),
    .pop       (pop),
    .pop_data  (head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Overflow only when the push is actually lost; set beats clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (s1_valid && fifo_full && !pop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  assign rd_id   = rd_valid ? head.frame.id   : '0;
  assign rd_dlc  = rd_valid ? head.frame.dlc  : '0;
  assign rd_data = rd_valid ? head.frame.data : '0;
  assign rd_filt = rd_valid ? head.filt       : '0;
`ifdef CAN_RX_TIMESTAMP_EN
  assign rd_ts   = rd_valid ? head.ts         : '0;
`endif

endmodule

// File: tb/tb_can_rx_filter_fifo.sv
// tb/tb_can_rx_filter_fifo.sv - directed self-checking bench for can_rx_filter_fifo
module tb_can_rx_filter_fifo;

  localparam int NF  = 4;
  localparam int DEP = 8;
  localparam int TSW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [10:0] rx_id;
  logic [3:0]  rx_dlc;
  logic [63:0] rx_data;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [10:0] cfg_id;
  logic [10:0] cfg_mask;
  logic        cfg_en;
  logic        rd_valid;
  logic        rd_ready;
  logic [10:0] rd_id;
  logic [3:0]  rd_dlc;
  logic [63:0] rd_data;
  logic [1:0]  rd_filt;
`ifdef CAN_RX_TIMESTAMP_EN
  logic [TSW-1:0] rd_ts;
`endif
  logic [3:0]  count;
  logic        ovf;
  logic        ovf_clr;

  int n_checks = 0;
  int n_fail   = 0;

  can_rx_filter_fifo #(
    .NUM_FILTERS (NF),
    .DEPTH       (DEP),
    .TS_WIDTH    (TSW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_id    (rx_id),
    .rx_dlc   (rx_dlc),
    .rx_data  (rx_data),
    .cfg_we   (cfg_we),
    .cfg_idx  (cfg_idx),
    .cfg_id   (cfg_id),
    .cfg_mask (cfg_mask),
    .cfg_en   (cfg_en),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_id    (rd_id),
    .rd_dlc   (rd_dlc),
    .rd_data  (rd_data),
    .rd_filt  (rd_filt),
`ifdef CAN_RX_TIMESTAMP_EN
    .rd_ts    (rd_ts),
`endif
    .count    (count),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
    rx_valid = 1'b1;
    rx_id    = id;
    rx_dlc   = dlc;
    rx_data  = data;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic cfg_bank(input logic [1:0] idx, input logic [10:0] id, input logic [10:0] mask, input logic en);
    cfg_we   = 1'b1;
    cfg_idx  = idx;
    cfg_id   = id;
    cfg_mask = mask;
    cfg_en   = en;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  logic [10:0] exp_ids [8];
`ifdef CAN_RX_TIMESTAMP_EN
  logic [TSW-1:0] t1, t2, td;
`endif

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_id = '0; rx_dlc = '0; rx_data = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_id = '0; cfg_mask = '0; cfg_en = 1'b0;
    rd_ready = 1'b0; ovf_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_rd_valid", 64'(rd_valid), 64'h0);
    check("rst_count",    64'(count),    64'h0);
    check("rst_ovf",      64'(ovf),      64'h0);
    check("rst_rd_id",    64'(rd_id),    64'h0);
    check("rst_rd_data",  rd_data,       64'h0);

    // Accept-all, two-edge latency
    send(11'h123, 4'd1, 64'hAB);
    check("aa_lat_s1", 64'(rd_valid), 64'h0);
    tick();
    check("aa_rd_valid", 64'(rd_valid),     64'h1);
    check("aa_rd_id",    64'(rd_id),        64'h123);
    check("aa_rd_dlc",   64'(rd_dlc),       64'h1);
    check("aa_rd_data",  64'(rd_data[7:0]), 64'hAB);
    check("aa_rd_filt",  64'(rd_filt),      64'h0);
    check("aa_count",    64'(count),        64'h1);
    pop_one();
    check("aa_pop_valid", 64'(rd_valid), 64'h0);
    check("aa_pop_zero",  64'(rd_id),    64'h0);

    // rd_ready while empty does nothing
    pop_one();
    check("empty_pop_count", 64'(count), 64'h0);

    // Filtering with bank 2
    cfg_bank(2'd2, 11'h120, 11'h7F0, 1'b1);
    send(11'h123, 4'd2, 64'h11);
    send(11'h223, 4'd2, 64'h22);
    tick();
    check("flt_count",   64'(count),   64'h1);
    check("flt_rd_id",   64'(rd_id),   64'h123);
    check("flt_rd_filt", 64'(rd_filt), 64'h2);
    pop_one();
    cfg_bank(2'd0, 11'h123, 11'h7FF, 1'b1);
    send(11'h123, 4'd2, 64'h33);
    tick();
    check("flt_low_filt", 64'(rd_filt), 64'h0);
    pop_one();

    // Config written on the same edge a frame is sampled: old settings apply
    cfg_we = 1'b1; cfg_idx = 2'd3; cfg_id = 11'h555; cfg_mask = 11'h7FF; cfg_en = 1'b1;
    rx_valid = 1'b1; rx_id = 11'h555; rx_dlc = 4'd0; rx_data = '0;
    tick();
    cfg_we = 1'b0; rx_valid = 1'b0;
    tick();
    check("cfg_same_edge_drop", 64'(count), 64'h0);
    send(11'h555, 4'd0, 64'h0);
    tick();
    check("cfg_new_count", 64'(count),   64'h1);
    check("cfg_new_filt",  64'(rd_filt), 64'h3);
    pop_one();

    // Overflow: 10 back-to-back accepted frames into 8 entries
    for (int i = 0; i < 10; i++) send(11'h120 + 11'(i), 4'd8, 64'(i));
    tick();
    check("ovf_count", 64'(count), 64'h8);
    check("ovf_flag",  64'(ovf),   64'h1);
    for (int i = 0; i < 8; i++) begin
      check("ovf_drain_id",   64'(rd_id), 64'h120 + 64'(i));
      check("ovf_drain_data", rd_data,    64'(i));
      pop_one();
    end
    check("ovf_drained_count", 64'(count),    64'h0);
    check("ovf_drained_valid", 64'(rd_valid), 64'h0);
    check("ovf_still_set",     64'(ovf),      64'h1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", 64'(ovf), 64'h0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 8; i++) send(11'h120 + 11'(i), 4'd1, 64'(i));
    tick();
    check("fpp_full", 64'(count), 64'h8);
    send(11'h12A, 4'd1, 64'hA);
    check("fpp_s1_count", 64'(count), 64'h8);
    pop_one();
    check("fpp_count", 64'(count), 64'h8);
    check("fpp_ovf",   64'(ovf),   64'h0);
    for (int i = 0; i < 7; i++) exp_ids[i] = 11'h121 + 11'(i);
    exp_ids[7] = 11'h12A;
    for (int i = 0; i < 8; i++) begin
      check("fpp_order", 64'(rd_id), 64'(exp_ids[i]));
      pop_one();
    end
    check("fpp_empty", 64'(count), 64'h0);

    // Reset mid-stream, third frame still in S1
    send(11'h124, 4'd1, 64'h1);
    send(11'h125, 4'd1, 64'h2);
    send(11'h126, 4'd1, 64'h3);
    check("rms_count_pre", 64'(count), 64'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rms_count",    64'(count),    64'h0);
    check("rms_rd_valid", 64'(rd_valid), 64'h0);
    tick();
    check("rms_s1_gone", 64'(count), 64'h0);
    send(11'h7FF, 4'd3, 64'h77);
    tick();
    check("rms_aa_valid", 64'(rd_valid), 64'h1);
    check("rms_aa_id",    64'(rd_id),    64'h7FF);
    check("rms_aa_filt",  64'(rd_filt),  64'h0);
    pop_one();

`ifdef CAN_RX_TIMESTAMP_EN
    // Frames five edges apart; repeated so the 4-bit counter wraps between pairs
    for (int r = 0; r < 4; r++) begin
      send(11'h100, 4'd0, 64'h0);
      for (int k = 0; k < 4; k++) tick();
      send(11'h101, 4'd0, 64'h0);
      tick();
      t1 = rd_ts;
      pop_one();
      t2 = rd_ts;
      pop_one();
      td = t2 - t1;
      check("ts_diff", 64'(td), 64'h5);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
